matmul_2x2_stream_host: RTL

- Initiator-side front end for the matmul_2x2 core.
- Accepts a serial stream of eight signed operands, assembles them into the A and B matrices, pulses core start and waits for core valid.
- Captures C and streams the four results back out, with ready/valid handshakes on both streams.
- Sits between a byte-level data path (DMA/UART bridge) and the matmul_2x2 core.

---
 rtl/matmul_2x2_stream_host.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/matmul_2x2_stream_host.sv
// matmul_2x2_stream_host: operand/result stream front end for matmul_2x2.
// Loads A and B from a beat stream, starts the core, streams C back out.
module matmul_2x2_stream_host #(
    parameter int BIT_PREC = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BIT_PREC-1:0]              in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*BIT_PREC:0]              out_data,
    output logic                             out_last,
    output logic                             start,
    output logic [1:0][1:0][BIT_PREC-1:0]    A,
    output logic [1:0][1:0][BIT_PREC-1:0]    B,
    input  logic                             valid,
    input  logic [1:0][1:0][2*BIT_PREC:0]    C,
    output logic                             busy,
    output logic                             timeout
);

    localparam int RW = 2 * BIT_PREC + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e                         state_q, state_d;
    logic [2:0]                     in_cnt_q, in_cnt_d;
    logic [1:0]                     out_cnt_q, out_cnt_d;
    logic [WW-1:0]                  wait_cnt_q, wait_cnt_d;
    logic [1:0][1:0][BIT_PREC-1:0]  a_q, b_q;
    logic [1:0][1:0][RW-1:0]        res_q;
    logic [RW-1:0]                  out_data_q;
    logic [1:0]                     nxt;
    logic                           load_en, cap_en, adv_en;

    assign A        = a_q;
    assign B        = b_q;
    assign out_data = out_data_q;
    assign out_last = (state_q == S_DRAIN) && (out_cnt_q == 2'd3);
    assign nxt      = out_cnt_q + 2'd1;

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_LOAD;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        in_ready   = 1'b0;
        start      = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        timeout    = 1'b0;
        load_en    = 1'b0;
        cap_en     = 1'b0;
        adv_en     = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_en = 1'b1;
                    if (in_cnt_q == 3'd7) begin
                        in_cnt_d = '0;
                        state_d  = S_START;
                    end else begin
                        in_cnt_d = in_cnt_q + 3'd1;
                    end
                end
            end
            S_START: begin
                start      = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (valid) begin
                    cap_en     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_DRAIN;
                end else if (wait_cnt_q == WLAST) begin
                    timeout    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    adv_en = 1'b1;
                    if (out_cnt_q == 2'd3) begin
                        out_cnt_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        out_cnt_d = nxt;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Operand assembly, result capture and output beat register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            out_data_q <= '0;
        end else begin
            if (load_en) begin
                if (!in_cnt_q[2]) begin
                    a_q[in_cnt_q[1]][in_cnt_q[0]] <= in_data;
                end else begin
                    b_q[in_cnt_q[1]][in_cnt_q[0]] <= in_data;
                end
            end
            if (cap_en) begin
                res_q      <= C;
                out_data_q <= C[0][0];
            end
            if (adv_en) begin
                if (out_cnt_q == 2'd3) begin
                    out_data_q <= '0;
                end else begin
                    out_data_q <= res_q[nxt[1]][nxt[0]];
                end
            end
        end
    end

endmodule
